// File: rtl/ehl_ddr_wrlvl_trng_mb.sv
// ehl_ddr_wrlvl_trng_mb: DDR3 write-leveling training engine.
// Sweeps a shared DQS delay tap over all TAPS settings. At each tap it issues
// SAMPLES one-cycle DQS pulses and majority-votes each lane's DRAM feedback.
// It then finds the single 0->1 CK edge per lane and reports a tap and a status.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start, abort      control from the PHY init sequencer (abort wins)
//   dfi_wrlvl_resp    per-lane DQ feedback, sampled at the end of each TWLO wait
//   dqs               write-leveling DQS pulse
//   tap               current delay tap, common to all lanes
//   busy, done        training in progress / training finished (level)
//   status, result    per-lane pass flag and edge tap (lane n at [n*TAP_W +: TAP_W])
//   rv                raw voted capture vectors (only with WRLVL_DEBUG_EN)
// Optional feature macro: WRLVL_DEBUG_EN
module ehl_ddr_wrlvl_trng_mb #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned TAP_W   = 4,
    parameter int unsigned SAMPLES = 3,
    parameter int unsigned GAP     = 8,
    parameter int unsigned TWLO    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LANES-1:0]         dfi_wrlvl_resp,
    output logic                     dqs,
    output logic [TAP_W-1:0]         tap,
    output logic                     busy,
    output logic                     done,
    output logic [LANES-1:0]         status,
    output logic [LANES*TAP_W-1:0]   result
`ifdef WRLVL_DEBUG_EN
    ,
    output logic [LANES*(2**TAP_W)-1:0] rv
`endif
);

    localparam int unsigned TAPS    = 2 ** TAP_W;
    localparam int unsigned CNT_MAX = (GAP > TWLO) ? GAP : TWLO;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SMP_W   = 3;
    localparam int unsigned VOTE_W  = 3;
    localparam int unsigned EDGE_W  = TAP_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_PULSE = 3'd2,
        S_WAITR = 3'd3,
        S_EVAL  = 3'd4
    } state_e;

    state_e                            state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [SMP_W-1:0]                  smp_q;
    logic [LANES-1:0][VOTE_W-1:0]      votes_q;
    logic [LANES-1:0][TAPS-1:0]        vec_q;
    logic [TAP_W-1:0]                  tap_q;
    logic                              dqs_q;
    logic                              busy_q;
    logic                              done_q;
    logic [LANES-1:0]                  status_q;
    logic [LANES-1:0][TAP_W-1:0]       result_q;

    logic [LANES-1:0][VOTE_W-1:0]      votes_nx_c;
    logic [LANES-1:0]                  vote_bit_c;
    logic [LANES-1:0][EDGE_W-1:0]      edge_cnt_c;
    logic [LANES-1:0][TAP_W-1:0]       edge_idx_c;

    // Vote accumulation including the response being sampled this edge.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            votes_nx_c[l] = votes_q[l] + VOTE_W'(dfi_wrlvl_resp[l]);
            vote_bit_c[l] = (votes_nx_c[l] > VOTE_W'(SAMPLES / 2));
        end
    end

    // Count rising edges in each lane's capture vector; remember the last one.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            edge_cnt_c[l] = '0;
            edge_idx_c[l] = '0;
            for (int i = 1; i < TAPS; i++) begin
                if (!vec_q[l][i-1] && vec_q[l][i]) begin
                    edge_cnt_c[l] = edge_cnt_c[l] + EDGE_W'(1);
                    edge_idx_c[l] = TAP_W'(i);
                end
            end
        end
    end

    // Training FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smp_q    <= '0;
            votes_q  <= '0;
            vec_q    <= '0;
            tap_q    <= '0;
            dqs_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= '0;
            result_q <= '0;
        end else if (abort) begin
            // tap and result deliberately hold across an abort
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smp_q    <= '0;
            votes_q  <= '0;
            dqs_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_GAP;
                        cnt_q    <= '0;
                        smp_q    <= '0;
                        votes_q  <= '0;
                        vec_q    <= '0;
                        tap_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        status_q <= '0;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        cnt_q   <= '0;
                        dqs_q   <= 1'b1;
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    dqs_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAITR;
                end
                S_WAITR: begin
                    if (cnt_q == CNT_W'(TWLO - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                        if (smp_q != SMP_W'(SAMPLES - 1)) begin
                            smp_q   <= smp_q + SMP_W'(1);
                            votes_q <= votes_nx_c;
                        end else begin
                            smp_q   <= '0;
                            votes_q <= '0;
                            for (int l = 0; l < LANES; l++) begin
                                vec_q[l][tap_q] <= vote_bit_c[l];
                            end
                            // last tap: stay at TAPS-1 and evaluate
                            if (tap_q != TAP_W'(TAPS - 1)) begin
                                tap_q <= tap_q + TAP_W'(1);
                            end else begin
                                state_q <= S_EVAL;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    for (int l = 0; l < LANES; l++) begin
                        status_q[l] <= (edge_cnt_c[l] == EDGE_W'(1));
                        result_q[l] <= (edge_cnt_c[l] == EDGE_W'(1)) ? edge_idx_c[l] : '0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dqs    = dqs_q;
    assign tap    = tap_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;
    assign result = result_q;
`ifdef WRLVL_DEBUG_EN
    assign rv     = vec_q;
`endif

endmodule
